// File: rtl/cp0_exc_unit_pkg.sv
// Shared MIPS CP0 definitions: register numbers, SR/Cause field positions,
// ExcCode values and the USER/HANDLER mode encoding.
package mips_defs;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   localparam int SR_IM_LSB    = 10;
   localparam int SR_EXL_BIT   = 1;
   localparam int SR_IE_BIT    = 0;
   localparam int CAUSE_BD_BIT = 31;
   localparam int CAUSE_IP_LSB = 10;
   localparam int CAUSE_EC_LSB = 2;

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   typedef enum logic {
      MODE_USER    = 1'b0,
      MODE_HANDLER = 1'b1
   } cp0_mode_e;

   // A faulting delay-slot instruction restarts at its branch, one word back.
   function automatic logic [31:0] restart_pc(input logic [31:0] pc, input logic bd);
      return bd ? (pc - 32'd4) : pc;
   endfunction

endpackage

// File: rtl/cp0_exc_unit_if.sv
// Pipeline <-> CP0 exception unit signal bundle.
interface cp0_exc_unit_if;
   logic [4:0]  exc_code;
   logic [31:0] pc_m;
   logic        bd_m;
   logic        m_valid;
   logic [5:0]  hw_int;
   logic        cp0_we;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic        eret_m;
   logic [31:0] cp0_rdata;
   logic        exc_req;
   logic [31:0] exc_pc;
   logic [31:0] epc_out;

   modport master (
      output exc_code, pc_m, bd_m, m_valid, hw_int,
             cp0_we, cp0_addr, cp0_wdata, eret_m,
      input  cp0_rdata, exc_req, exc_pc, epc_out
   );

   modport slave (
      input  exc_code, pc_m, bd_m, m_valid, hw_int,
             cp0_we, cp0_addr, cp0_wdata, eret_m,
      output cp0_rdata, exc_req, exc_pc, epc_out
   );
endinterface

// File: rtl/cp0_exc_unit_int_sync.sv
// Two-flop synchroniser for the asynchronous external interrupt lines.
module cp0_int_sync #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= '0;
         dout <= '0;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt unit at the end of M: holds SR/Cause/EPC/PRId,
// raises flush+redirect on exceptions/interrupts and serves mfc0/mtc0/eret.
module cp0_exc_unit
   import mips_defs::*;
#(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
   parameter logic [31:0] PRID_VAL     = 32'h0000_0000
) (
   input logic           clk,
   input logic           reset,
   cp0_exc_unit_if.slave bus
);

   cp0_mode_e   mode;
   logic [5:0]  sr_im;
   logic        sr_ie;
   logic        cause_bd;
   logic [5:0]  cause_ip;
   logic [4:0]  cause_exc;
   logic [31:0] epc;
   logic [5:0]  int_sync;

   logic        exl;
   logic        int_pend;
   logic        exc_pend;
   logic        exc_req;
   logic [31:0] sr_word;
   logic [31:0] cause_word;
   logic        unused_wdata;

   cp0_int_sync #(.WIDTH(6)) u_int_sync (
      .clk   (clk),
      .reset (reset),
      .din   (bus.hw_int),
      .dout  (int_sync)
   );

   // exc_req is forced low while reset is held so the flush never fires mid-reset.
   always_comb begin
      exl      = (mode == MODE_HANDLER);
      int_pend = (|(int_sync & sr_im)) & sr_ie & ~exl & bus.m_valid;
      exc_pend = (bus.exc_code != EXC_NONE) & ~exl & bus.m_valid;
      exc_req  = (int_pend | exc_pend) & ~reset;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode      <= MODE_USER;
         sr_im     <= '0;
         sr_ie     <= 1'b0;
         cause_bd  <= 1'b0;
         cause_ip  <= '0;
         cause_exc <= '0;
         epc       <= '0;
      end else begin
         cause_ip <= int_sync;
         if (exc_req) begin
            epc       <= restart_pc(bus.pc_m, bus.bd_m);
            cause_bd  <= bus.bd_m;
            cause_exc <= int_pend ? EXC_INT : bus.exc_code;
            mode      <= MODE_HANDLER;
         end else begin
            if (bus.cp0_we) begin
               case (bus.cp0_addr)
                  CP0_SR: begin
                     sr_im <= bus.cp0_wdata[SR_IM_LSB +: 6];
                     sr_ie <= bus.cp0_wdata[SR_IE_BIT];
                     mode  <= bus.cp0_wdata[SR_EXL_BIT] ? MODE_HANDLER : MODE_USER;
                  end
                  CP0_EPC: epc <= bus.cp0_wdata;
                  default: ;
               endcase
            end
            // eret is ordered after mtc0 so it always leaves HANDLER mode.
            if (bus.eret_m) begin
               mode <= MODE_USER;
            end
         end
      end
   end

   always_comb begin
      sr_word                          = '0;
      sr_word[SR_IM_LSB +: 6]          = sr_im;
      sr_word[SR_EXL_BIT]              = exl;
      sr_word[SR_IE_BIT]               = sr_ie;
      cause_word                       = '0;
      cause_word[CAUSE_BD_BIT]         = cause_bd;
      cause_word[CAUSE_IP_LSB +: 6]    = cause_ip;
      cause_word[CAUSE_EC_LSB +: 5]    = cause_exc;
   end

   always_comb begin
      case (bus.cp0_addr)
         CP0_SR:    bus.cp0_rdata = sr_word;
         CP0_CAUSE: bus.cp0_rdata = cause_word;
         CP0_EPC:   bus.cp0_rdata = epc;
         CP0_PRID:  bus.cp0_rdata = PRID_VAL;
         default:   bus.cp0_rdata = '0;
      endcase
   end

   assign bus.exc_req = exc_req;
   assign bus.exc_pc  = exc_req ? HANDLER_ADDR : epc;
   assign bus.epc_out = epc;

   assign unused_wdata = ^{bus.cp0_wdata[31:16], bus.cp0_wdata[9:2]};

endmodule
